// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one multi-cycle memory port among NUM_CLIENTS cache controllers
//
// Grants one client at a time for a whole burst and routes read returns to the
// client that issued them, including after that client has dropped its request.
// Optional feature: define MEM_ARBITER_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cli_req/en/wr     per-client request (held per burst), access strobe, write flag
//   cli_addr/wdata    packed per-client address and write data
//   cli_gnt           registered one-hot grant
//   cli_ready         granted client's strobe is accepted this cycle
//   cli_valid         read data valid, routed to the issuing client
//   cli_rdata         memory read data broadcast
//   mem_*             memory port (en, wr, addr, wdata out; rdata, valid in)
//   busy              arbiter not idle
module mem_arbiter #(
  parameter int NUM_CLIENTS     = 2,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cli_req,
  input  logic [NUM_CLIENTS-1:0]        cli_en,
  input  logic [NUM_CLIENTS-1:0]        cli_wr,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata,
  output logic [NUM_CLIENTS-1:0]        cli_gnt,
  output logic                          cli_ready,
  output logic [NUM_CLIENTS-1:0]        cli_valid,
  output logic [DATA_W-1:0]             cli_rdata,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_valid,
  output logic                          busy
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] own;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic [CNT_W-1:0] outs;
  logic [CNT_W-1:0] outs_nxt;
  logic             in_grant;
  logic             ret;
  logic             rd_acc;
`ifdef MEM_ARBITER_RR_EN
  logic [IDX_W-1:0] last;
`endif

  // Arbitration: scan all clients starting from the highest-priority slot.
  always_comb begin
    int j;
    winner  = '0;
    any_req = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
`ifdef MEM_ARBITER_RR_EN
      // Start just after the last owner so it gets the lowest priority.
      j = int'(last) + 1 + i;
      if (j >= NUM_CLIENTS) j = j - NUM_CLIENTS;
`else
      j = i;
`endif
      if (!any_req && cli_req[j]) begin
        winner  = IDX_W'(j);
        any_req = 1'b1;
      end
    end
  end

  assign in_grant = (state == GRANT);
  // A return with nothing outstanding is stray: ignore it so outs cannot underflow.
  assign ret      = mem_valid & (outs != '0);
  // A same-cycle return frees a slot, so a full pipeline can still accept.
  assign cli_ready = in_grant & ((outs < CNT_W'(MAX_OUTSTANDING)) | ret);
  // The strobe in the cycle the owner drops req is ignored.
  assign mem_en    = in_grant & cli_req[own] & cli_en[own] & cli_ready;
  assign mem_wr    = in_grant & cli_wr[own];
  assign mem_addr  = in_grant ? cli_addr[int'(own)*ADDR_W +: ADDR_W]  : '0;
  assign mem_wdata = in_grant ? cli_wdata[int'(own)*DATA_W +: DATA_W] : '0;
  assign rd_acc    = mem_en & ~mem_wr;
  assign cli_rdata = mem_rdata;
  assign busy      = (state != IDLE);

  always_comb begin
    cli_valid = '0;
    if (state != IDLE) cli_valid[own] = ret;
  end

  always_comb begin
    case ({rd_acc, ret})
      2'b10:   outs_nxt = outs + CNT_W'(1);
      2'b01:   outs_nxt = outs - CNT_W'(1);
      default: outs_nxt = outs;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      own     <= '0;
      outs    <= '0;
      cli_gnt <= '0;
`ifdef MEM_ARBITER_RR_EN
      last    <= IDX_W'(NUM_CLIENTS - 1);
`endif
    end else begin
      outs <= outs_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            own     <= winner;
            cli_gnt <= NUM_CLIENTS'(1) << winner;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!cli_req[own]) begin
            cli_gnt <= '0;
`ifdef MEM_ARBITER_RR_EN
            last    <= own;
`endif
            state   <= (outs_nxt == '0) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (outs_nxt == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized scoreboard bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int N = 2, AW = 16, DW = 16, MAXO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] cli_req, cli_en, cli_wr, cli_gnt, cli_valid;
  logic [N*AW-1:0] cli_addr;
  logic [N*DW-1:0] cli_wdata;
  logic cli_ready, mem_en, mem_wr, mem_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, cli_rdata;

  mem_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_en(cli_en), .cli_wr(cli_wr),
    .cli_addr(cli_addr), .cli_wdata(cli_wdata), .cli_gnt(cli_gnt), .cli_ready(cli_ready),
    .cli_valid(cli_valid), .cli_rdata(cli_rdata), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .busy(busy));

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, lat = 4;
  bit spur = 1'b0;

  typedef struct { int due; logic [DW-1:0] data; } mrd_t;
  typedef struct { int cli; logic [DW-1:0] data; } sb_t;
  mrd_t mq[$];   // memory pipeline
  sb_t  sb[$];   // expected read returns

  // Reference model state: phase 0 idle, 1 granted, 2 draining.
  int m_phase = 0, m_own = 0, m_last = N - 1;
  int m_fl[$];   // issuing client of every read in flight, oldest first

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return (a * 16'd3) ^ 16'hA5C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    spur = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_valid = 1'b1;
      mem_rdata = mq[0].data;
    end else begin
      mem_valid = 1'b0;
      mem_rdata = DW'($urandom);
    end
  endtask

  task automatic drive(input int c, input bit rq, input bit en, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    cli_req[c] = rq; cli_en[c] = en; cli_wr[c] = wr;
    cli_addr[c*AW +: AW] = a;
    cli_wdata[c*DW +: DW] = d;
  endtask

  task automatic clear();
    cli_req = '0; cli_en = '0; cli_wr = '0; cli_addr = '0; cli_wdata = '0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    clear();
    while ((busy || mq.size() > 0) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
  endtask

  function automatic int pick();
`ifdef MEM_ARBITER_RR_EN
    for (int k = 1; k <= N; k++) if (cli_req[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int k = 0; k < N; k++) if (cli_req[k]) return k;
`endif
    return -1;
  endfunction

  // Memory responder plus reference model, sampled on the falling edge.
  always @(negedge clk) begin : model
    logic [N-1:0] eg, ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit gr, ret, rdy, acc, wr;
    int w;
    if (mem_valid && !spur && mq.size() > 0) void'(mq.pop_front());
    if (mem_en && !mem_wr) mq.push_back('{cyc + lat, mdata(mem_addr)});
    if (!rst_n) begin
      m_phase = 0; m_last = N - 1;
      m_fl.delete(); sb.delete();
      chk("rst_out", {busy, cli_ready, mem_en, mem_wr, cli_valid, cli_gnt}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
    end else begin
      gr  = (m_phase == 1);
      ret = mem_valid && (m_fl.size() > 0);
      eg  = gr ? (N'(1) << m_own) : '0;
      ev  = ret ? (N'(1) << m_fl[0]) : '0;
      rdy = gr && ((m_fl.size() < MAXO) || ret);
      wr  = gr && cli_wr[m_own];
      acc = gr && cli_req[m_own] && cli_en[m_own] && rdy;
      ea  = gr ? cli_addr[m_own*AW +: AW] : '0;
      ed  = gr ? cli_wdata[m_own*DW +: DW] : '0;
      chk("gnt", cli_gnt, eg);
      chk("valid", cli_valid, ev);
      chk("ready", cli_ready, rdy);
      chk("mem_en", mem_en, acc);
      chk("mem_wr", mem_wr, wr);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("busy", busy, m_phase != 0);
      if (ret) void'(m_fl.pop_front());
      if (acc && !wr) begin
        m_fl.push_back(m_own);
        sb.push_back('{m_own, mdata(ea)});
      end
      case (m_phase)
        0: begin
          w = pick();
          if (w >= 0) begin m_own = w; m_phase = 1; end
        end
        1: if (!cli_req[m_own]) begin
          m_last = m_own;
          m_phase = (m_fl.size() == 0) ? 0 : 2;
        end
        default: if (m_fl.size() == 0) m_phase = 0;
      endcase
    end
  end

  // Scoreboard monitor: every read return must match the oldest expected one.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (rst_n && cli_valid != '0) begin
      if (sb.size() == 0) chk("sb_stray", cli_valid, 0);
      else begin
        e = sb.pop_front();
        chk("sb_client", cli_valid, N'(1) << e.cli);
        chk("sb_data", cli_rdata, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int g[$];
    int rem[N];
    bit rq[N], iss[N];
    logic [N-1:0] prev_g;
    clear();
    mem_valid = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    chk("reset_gnt", cli_gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", {cli_ready, mem_en, mem_wr}, 0);
    rst_n = 1'b1;

    // Single read burst from client 1, memory latency 4.
    lat = 4;
    tick(); drive(1, 1, 0, 0, 0, 0);
    tick(); chk("t1_gnt", cli_gnt, 2'b10);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 0, AW'(16'h0010 + 2*i), 0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 0);
    repeat (6) tick();
    wait_idle("t1");

    // Early release: client 0 issues two reads then drops req.
    tick(); drive(0, 1, 0, 0, 0, 0);
    tick(); drive(0, 1, 1, 0, 16'h0020, 0);
    tick(); drive(0, 1, 1, 0, 16'h0022, 0);
    tick(); drive(0, 0, 1, 0, 16'h0024, 0);
    tick(); clear();
    chk("t2_drain_gnt", cli_gnt, 0);
    chk("t2_drain_busy", busy, 1);
    wait_idle("t2");

    // Simultaneous requesters with one-read bursts.
    lat = 2;
    iss = '{default: 0};
    prev_g = '0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cli_gnt != '0 && prev_g == '0) g.push_back(cli_gnt[1] ? 1 : 0);
      prev_g = cli_gnt;
      for (int c = 0; c < N; c++) begin
        if (cli_gnt[c] && !iss[c]) begin drive(c, 1, 1, 0, AW'(16'h0040 + c), 0); iss[c] = 1; end
        else if (cli_gnt[c]) begin drive(c, 0, 0, 0, 0, 0); iss[c] = 0; end
        else drive(c, 1, 0, 0, 0, 0);
      end
    end
    wait_idle("t3");
    chk("t3_grant_count", g.size() >= 6, 1);
    for (int i = 0; i < 6 && i < g.size(); i++) begin
`ifdef MEM_ARBITER_RR_EN
      chk("t3_grant_order", g[i], (1 + i) % 2);
`else
      chk("t3_grant_order", g[i], 0);
`endif
    end

    // Outstanding limit with slow returns.
    lat = 6;
    tick(); drive(0, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 1, 0, AW'(16'h0030 + 2*i), 0);
      #1;
      if (i == 4 || i == 5) begin
        chk("t4_full_ready", cli_ready, 0);
        chk("t4_full_en", mem_en, 0);
      end
      if (i == 6) chk("t4_ret_ready", {cli_ready, mem_en}, 2'b11);
      tick();
    end
    wait_idle("t4");

    // Write burst from client 1.
    tick(); drive(1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 1, AW'(16'h0100 + 2*i), 16'hBEEF);
      #1;
      chk("t5_wr", {mem_en, mem_wr}, 2'b11);
      chk("t5_addr", mem_addr, 16'h0100 + 2*i);
      chk("t5_data", mem_wdata, 16'hBEEF);
      tick();
    end
    clear();
    tick();
    chk("t5_direct_idle", busy, 0);

    // Asynchronous reset while draining.
    lat = 8;
    tick(); drive(0, 1, 0, 0, 0, 0);
    tick(); drive(0, 1, 1, 0, 16'h0050, 0);
    tick(); drive(0, 1, 1, 0, 16'h0052, 0);
    tick(); clear();
    tick();
    chk("t6_in_drain", {busy, cli_gnt}, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {busy, cli_ready, mem_en, mem_wr, cli_valid, cli_gnt}, 0);
    chk("t6_rst_bus", {mem_addr, mem_wdata}, 0);
    tick();
    rst_n = 1'b1;
    wait_idle("t6");
    tick();
    mem_valid = 1'b1; spur = 1'b1;
    #1;
    chk("t6_stray_valid", cli_valid, 0);

    // Randomized traffic.
    rq = '{default: 0};
    rem = '{default: 0};
    for (int n = 0; n < 1500; n++) begin
      tick();
      if (n % 300 == 0) lat = $urandom_range(1, 6);
      for (int c = 0; c < N; c++) begin
        if (!rq[c]) begin
          if ($urandom_range(0, 3) == 0) begin rq[c] = 1; rem[c] = $urandom_range(1, 6); end
        end else if (cli_gnt[c]) begin
          if (rem[c] == 0) rq[c] = 0; else rem[c]--;
        end
        drive(c, rq[c], $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              AW'($urandom), DW'($urandom));
      end
      if (mq.size() == 0 && !mem_valid && $urandom_range(0, 15) == 0) begin
        mem_valid = 1'b1; spur = 1'b1; mem_rdata = DW'($urandom);
      end
    end
    wait_idle("random");
    tick();
    chk("sb_leftover", sb.size(), 0);
    chk("mem_leftover", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised arbiter that lets NUM_CLIENTS cache controllers share the single multi-cycle main-memory port, replacing the fixed two-way instruction/data select. The arbiter grants one client at a time, holding the grant for a whole burst. It tracks in-flight reads so that returning data is routed to the client that issued them, even after that client has released the bus. It sits between the I-cache/D-cache (and any future requesters) and `memory4c`.

## Interface
Parameters:
- NUM_CLIENTS, 2, number of requesters (≥2); index 0 = I-cache, 1 = D-cache
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MAX_OUTSTANDING, 4, maximum in-flight reads; matches the memory pipeline depth

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- cli_req  in  NUM_CLIENTS  client holds high for the entire transaction
- cli_en  in  NUM_CLIENTS  per-cycle access strobe
- cli_wr  in  NUM_CLIENTS  1 = write, 0 = read
- cli_addr  in  NUM_CLIENTS*ADDR_W  packed addresses, client i at [i*ADDR_W +: ADDR_W]
- cli_wdata  in  NUM_CLIENTS*DATA_W  packed write data
- cli_gnt  out  NUM_CLIENTS  registered one-hot grant
- cli_ready  out  1  granted client's access is accepted this cycle
- cli_valid  out  NUM_CLIENTS  read data valid, routed to the issuing client
- cli_rdata  out  DATA_W  mem_rdata broadcast to all clients
- mem_en, mem_wr  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W; mem_valid  in  1  memory read return
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, GRANT, DRAIN. Registered signals: owner index (`own`), outstanding counter `outs` (width $clog2(MAX_OUTSTANDING+1)), round-robin pointer `last`.
- IDLE: if any cli_req is high, select the winner, load `own`, and go to GRANT. cli_gnt is all zero.
- GRANT:
  - cli_gnt[own] = 1.
  - mem_addr, mem_wdata and mem_wr are muxed combinationally from client `own`.
  - cli_ready = (outs < MAX_OUTSTANDING) | mem_valid.
  - mem_en = cli_en[own] & cli_ready.
- Counter update each cycle: `outs` += accepted read (mem_en & ~mem_wr), `outs` -= mem_valid. Both events in the same cycle leave `outs` unchanged. Writes never count.
- Leaving GRANT, when cli_req[own] falls:
  - next outs == 0 → IDLE
  - otherwise → DRAIN
  - In both cases, `last` ← `own`. Any cli_en in the cycle req falls is ignored.
- DRAIN: cli_gnt = 0 and mem_en = 0. Go to IDLE on the cycle the counter reaches 0.
- Routing: cli_valid[own] = mem_valid in GRANT and DRAIN. A mem_valid seen with outs == 0 is ignored: no cli_valid, and the counter does not underflow.
- mem_en/mem_wr/mem_addr/mem_wdata are 0 outside GRANT.

## Timing
- Reset values: cli_gnt = 0, cli_valid = 0, cli_ready = 0, mem_en = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0, busy = 0, outs = 0, state = IDLE, `last` = NUM_CLIENTS-1.
- Grant latency: req sampled in IDLE at edge k; cli_gnt is high from cycle k+1. The first access can issue in cycle k+1.
- Re-arbitration: at least one IDLE cycle occurs between consecutive grants, so a zero-gap handover never happens.
- Read return: cli_valid is combinational from mem_valid, with zero added latency.
- Reset asserted mid-transaction: everything returns immediately to reset values, and in-flight returns after reset are ignored.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration. The search starts at (`last`+1) mod NUM_CLIENTS, so the just-served client has lowest priority.
- Not defined: fixed priority, where the lowest index wins and `last` is unused. Client 0 (I-cache) always beats client 1, as in the legacy two-way select.

## Test plan
- Single read burst (NUM_CLIENTS=2, memory latency 4): client 1 holds req and issues 4 reads at 0x0010–0x0016.
  - cli_gnt = 2'b10 one cycle after req.
  - Four cli_valid[1] pulses arrive 4 cycles after each issue.
  - busy stays high until the last return.
- Drain after early release: client 0 issues 2 reads, then drops req the next cycle.
  - State goes to DRAIN, with cli_gnt = 0 and mem_en = 0.
  - Both returns raise cli_valid[0] only.
  - State returns to IDLE when outs = 0.
- Simultaneous requests: both clients request continuously with one-read bursts.
  - With MEM_ARBITER_RR_EN: grants alternate 0, 1, 0, 1.
  - Without it: client 0 wins every arbitration.
- Outstanding limit (MAX_OUTSTANDING=2): a client strobes cli_en on 3 consecutive cycles with memory returns delayed.
  - cli_ready = 0 on the third cycle and no mem_en is issued.
  - Concurrent mem_valid re-enables ready in that same cycle.
- Write burst: 4 writes from client 1 of 0xBEEF to 0x0100.
  - mem_wr = 1 with correct addr/data on each; outs stays 0.
  - Dropping req returns the arbiter directly to IDLE.
- Async reset mid-DRAIN: assert rst_n low between clock edges.
  - All outputs are 0 immediately.
  - A mem_valid after release produces no cli_valid.
